// File: rtl/traffic_phase_ctrl.sv
// Two-road intersection phase controller with pedestrian walk and flash mode.
// Ports: clk, reset (async high), tick_in, ped_req, flash_en -> ns_light,
//   ew_light ({R,Y,G}), ped_walk, phase (debug state encoding).
module traffic_phase_ctrl #(
  parameter int CNT_W        = 4,
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 2,
  parameter int WALK_TICKS   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    NS_G  = 3'd0,
    NS_Y  = 3'd1,
    RED_A = 3'd2,
    EW_G  = 3'd3,
    EW_Y  = 3'd4,
    RED_B = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_e;

  localparam logic [CNT_W-1:0] G_M1 = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_M1 = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] R_M1 = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] W_M1 = CNT_W'(WALK_TICKS - 1);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  state_e           state_q, state_d;
  state_e           seq_nxt;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dur_m1;
  logic             ped_q, ped_d;
  logic             blink_q, blink_d;

  // Phase length and successor in the normal sequence.
  always_comb begin
    dur_m1  = R_M1;
    seq_nxt = RED_B;
    unique case (state_q)
      NS_G:  begin dur_m1 = G_M1; seq_nxt = NS_Y;  end
      NS_Y:  begin dur_m1 = Y_M1; seq_nxt = RED_A; end
      RED_A: begin dur_m1 = R_M1; seq_nxt = EW_G;  end
      EW_G:  begin dur_m1 = G_M1; seq_nxt = EW_Y;  end
      EW_Y:  begin dur_m1 = Y_M1; seq_nxt = RED_B; end
      RED_B: begin
        dur_m1  = R_M1;
        seq_nxt = ped_q ? WALK : NS_G;
      end
      WALK:  begin dur_m1 = W_M1; seq_nxt = NS_G;  end
      FLASH: begin dur_m1 = R_M1; seq_nxt = RED_B; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ped_d   = ped_q;
    blink_d = blink_q;
    if (flash_en) begin
      // Flash overrides everything; pending walk is kept.
      state_d = FLASH;
      if (state_q == FLASH) begin
        blink_d = blink_q ^ tick_in;
      end else begin
        cnt_d   = '0;
        blink_d = 1'b0;
      end
    end else if (state_q == FLASH) begin
      // Leaving flash restarts through all-red.
      state_d = RED_B;
      cnt_d   = '0;
      blink_d = 1'b0;
      ped_d   = ped_q | ped_req;
    end else begin
      if (ped_req && state_q != WALK) begin
        ped_d = 1'b1;
      end
      if (tick_in) begin
        if (cnt_q == dur_m1) begin
          state_d = seq_nxt;
          cnt_d   = '0;
          // Entering walk clears the request, beating a same-cycle press.
          if (seq_nxt == WALK) begin
            ped_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RED_B;
      cnt_q   <= '0;
      ped_q   <= 1'b0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ped_q   <= ped_d;
      blink_q <= blink_d;
    end
  end

  // Lamps decode straight from the registered state.
  always_comb begin
    ns_light = RED;
    ew_light = RED;
    ped_walk = 1'b0;
    unique case (state_q)
      NS_G:  ns_light = GRN;
      NS_Y:  ns_light = YEL;
      EW_G:  ew_light = GRN;
      EW_Y:  ew_light = YEL;
      WALK:  ped_walk = 1'b1;
      FLASH: begin
        ns_light = {1'b0, blink_q, 1'b0};
        ew_light = {1'b0, blink_q, 1'b0};
      end
      default: ;
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Randomized and directed bench for traffic_phase_ctrl against a
// tick-counting reference model of the phase sequence.
module tb_traffic_phase_ctrl;

  logic       clk;
  logic       reset;
  logic       tick_in;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic [2:0] phase;

  int errs;
  int checks;
  int cyc;

  // Reference model: phase index, ticks elapsed in phase, pending walk,
  // flash blink lamp.
  int mph;
  int mticks;
  bit mped;
  bit mblink;

  int dur [0:6] = '{8, 3, 2, 8, 3, 2, 4};

  traffic_phase_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .tick_in  (tick_in),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .phase    (phase)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [9:0] exp_vec();
    logic [2:0] n;
    logic [2:0] e;
    n = 3'b100;
    e = 3'b100;
    if (mph == 0) n = 3'b001;
    if (mph == 1) n = 3'b010;
    if (mph == 3) e = 3'b001;
    if (mph == 4) e = 3'b010;
    if (mph == 7) begin
      n = {1'b0, mblink, 1'b0};
      e = {1'b0, mblink, 1'b0};
    end
    return {3'(mph), n, e, mph == 6};
  endfunction

  function automatic bit sched_tick();
    return (cyc % 4) == 3;
  endfunction

  function automatic int successor(input int p, input bit pend);
    if (p == 5) return pend ? 6 : 0;
    if (p == 6) return 0;
    return p + 1;
  endfunction

  task automatic model_reset();
    mph    = 5;
    mticks = 0;
    mped   = 0;
    mblink = 0;
  endtask

  task automatic model_clk(input bit tk, input bit pr, input bit fe);
    bit pend_old;
    pend_old = mped;
    if (fe) begin
      if (mph == 7) begin
        if (tk) mblink = ~mblink;
      end else begin
        mph    = 7;
        mticks = 0;
        mblink = 0;
      end
    end else if (mph == 7) begin
      mph    = 5;
      mticks = 0;
      mblink = 0;
      if (pr) mped = 1;
    end else begin
      if (pr && mph != 6) mped = 1;
      if (tk) begin
        mticks++;
        if (mticks == dur[mph]) begin
          mph    = successor(mph, pend_old);
          mticks = 0;
          if (mph == 6) mped = 0;
        end
      end
    end
  endtask

  task automatic step(input bit tk, input bit pr, input bit fe);
    tick_in  = tk;
    ped_req  = pr;
    flash_en = fe;
    @(posedge clk);
    model_clk(tk, pr, fe);
    cyc++;
    #1;
    chk("lamps", {phase, ns_light, ew_light, ped_walk}, exp_vec());
  endtask

  task automatic sstep();
    step(sched_tick(), 1'b0, 1'b0);
  endtask

  task automatic run_to(input int ph, input int maxc);
    int n;
    n = 0;
    while (mph != ph && n < maxc) begin
      sstep();
      n++;
    end
    chk("reach", 32'(mph), 32'(ph));
  endtask

  task automatic do_reset();
    #3;
    reset = 1'b1;
    #1;
    chk("rst_lamps", {phase, ns_light, ew_light, ped_walk},
        {3'd5, 3'b100, 3'b100, 1'b0});
    @(negedge clk);
    @(negedge clk);
    tick_in  = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    reset    = 1'b0;
    model_reset();
    cyc = 0;
  endtask

  initial begin
    int n;
    int walks;
    bit fe;
    bit tk;
    bit pr;
    errs     = 0;
    checks   = 0;
    cyc      = 0;
    reset    = 1'b1;
    tick_in  = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", {phase, ns_light, ew_light, ped_walk},
        {3'd5, 3'b100, 3'b100, 1'b0});
    @(negedge clk);
    reset = 1'b0;

    // 1: free run, measure full sequence length on the DUT.
    run_to(0, 20);
    n = 0;
    while (phase == 3'd0 && n < 200) begin
      tk = sched_tick();
      step(tk, 1'b0, 1'b0);
      if (tk) n++;
    end
    while (phase != 3'd0 && n < 200) begin
      tk = sched_tick();
      step(tk, 1'b0, 1'b0);
      if (tk) n++;
    end
    chk("cycle_ticks", 32'(n), 32'd26);

    // 2: press during EW_G, walk served once.
    run_to(3, 200);
    step(sched_tick(), 1'b1, 1'b0);
    run_to(6, 200);
    chk("walk_on", {31'd0, ped_walk}, 32'd1);
    run_to(0, 200);
    walks = 0;
    repeat (110) begin
      sstep();
      if (ped_walk) walks++;
    end
    chk("no_rewalk", 32'(walks), 32'd0);

    // 3: presses on walk entry and during walk are ignored.
    run_to(3, 200);
    step(sched_tick(), 1'b1, 1'b0);
    run_to(5, 200);
    n = 0;
    while (!(mticks == 1 && sched_tick()) && n < 20) begin
      sstep();
      n++;
    end
    step(sched_tick(), 1'b1, 1'b0);
    chk("walk_entry", 32'(phase), 32'd6);
    repeat (3) sstep();
    step(sched_tick(), 1'b1, 1'b0);
    run_to(0, 200);
    walks = 0;
    repeat (110) begin
      sstep();
      if (ped_walk) walks++;
    end
    chk("ign_press", 32'(walks), 32'd0);

    // 4: flash from NS_G cnt=5, blink, then all-red restart.
    run_to(0, 200);
    n = 0;
    while (mticks != 5 && n < 40) begin
      sstep();
      n++;
    end
    step(1'b0, 1'b0, 1'b1);
    chk("flash_in", {ns_light, ew_light}, 6'b000000);
    n = 0;
    while (!sched_tick() && n < 8) begin
      step(1'b0, 1'b0, 1'b1);
      n++;
    end
    step(1'b1, 1'b0, 1'b1);
    chk("blink1", {ns_light, ew_light}, 6'b010010);
    repeat (8) step(sched_tick(), 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    chk("flash_out", 32'(phase), 32'd5);
    run_to(0, 20);

    // 5: tick held high from NS_G cnt=0, then async reset mid-clock.
    repeat (10) step(1'b1, 1'b0, 1'b0);
    chk("hold_tick", 32'(phase), 32'd1);
    do_reset();

    // 6: random stimulus with safety invariants.
    fe = 0;
    repeat (10000) begin
      if ($urandom_range(0, 199) == 0) fe = ~fe;
      tk = ($urandom_range(0, 3) == 0);
      pr = ($urandom_range(0, 15) == 0);
      step(tk, pr, fe);
      if (phase != 3'd7) begin
        chk("one_red", {31'd0, ns_light == 3'b100 || ew_light == 3'b100},
            32'd1);
        chk("onehot", {30'd0, $onehot(ns_light), $onehot(ew_light)}, 32'd3);
      end
      if (ped_walk)
        chk("walk_red", {ns_light, ew_light}, 6'b100100);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
